// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal reorder controller.
package bitrev_pkg;

   localparam int MIN_LOG2_DEF = 3;
   localparam int MAX_LOG2_DEF = 10;

   // One-hot controller states
   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_SCAN = 4'b0010,
      S_SWAP = 4'b0100,
      S_DONE = 4'b1000
   } state_t;

   // Reverse the low 'len' bits of value; bits at and above len come back 0.
   function automatic logic [MAX_LOG2_DEF-1:0] bit_rev(
      input logic [MAX_LOG2_DEF-1:0] value,
      input int                      len
   );
      logic [MAX_LOG2_DEF-1:0] r;
      r = '0;
      for (int b = 0; b < MAX_LOG2_DEF; b++) begin
         if ((b < len) && (len <= MAX_LOG2_DEF)) begin
            r[b] = value[len-1-b];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bit_rev_idx.sv
// Combinational variable-width bit reverser: reverses bits [L-1:0] of the
// index and drives bits [MAX_LOG2-1:L] to zero. Sizes above MAX_LOG2 are
// clamped so the shift amount never underflows.
module bit_rev_idx #(
   parameter int MAX_LOG2 = 10,
   parameter int LW       = 4
) (
   input  logic [MAX_LOG2-1:0] i_idx,
   input  logic [LW-1:0]       i_log2n,
   output logic [MAX_LOG2-1:0] o_rev
);

   logic [LW-1:0]       w_len;
   logic [LW-1:0]       w_shift;
   logic [MAX_LOG2-1:0] w_masked;
   logic [MAX_LOG2-1:0] w_full;

   assign w_len = (int'(i_log2n) > MAX_LOG2) ? LW'(MAX_LOG2) : i_log2n;

   // Keep only the low L index bits, then mirror the whole word: the L live
   // bits land in the top L positions in reversed order.
   generate
      for (genvar gi = 0; gi < MAX_LOG2; gi++) begin : g_rev
         assign w_masked[gi] = i_idx[gi] & (int'(w_len) > gi);
         assign w_full[gi]   = w_masked[MAX_LOG2-1-gi];
      end
   endgenerate

   // Slide the reversed field back down to bit 0.
   assign w_shift = LW'(MAX_LOG2) - w_len;
   assign o_rev   = w_full >> w_shift;

endmodule

// File: rtl/bit_rev_reorder_ctrl.sv
// In-place bit-reversal reorder controller driving both ports of a
// dual-port synchronous RAM. Each index i is scanned once; when rev(i) > i
// the pair is read in SCAN and cross-written in SWAP, so each pair is
// handled exactly once and an abort never leaves a half-swapped pair.
module bit_rev_reorder_ctrl
   import bitrev_pkg::*;
#(
   parameter int DATA_W   = 18,
   parameter int MAX_LOG2 = MAX_LOG2_DEF,
   parameter int MIN_LOG2 = MIN_LOG2_DEF,
   parameter int LW       = 4
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [LW-1:0]       i_log2n_in,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err,
   output logic [MAX_LOG2-1:0] o_addr_a,
   output logic [MAX_LOG2-1:0] o_addr_b,
   output logic                o_write_enable_a,
   output logic                o_write_enable_b,
   input  logic [DATA_W-1:0]   i_din_a,
   input  logic [DATA_W-1:0]   i_din_b,
   output logic [DATA_W-1:0]   o_dout_a,
   output logic [DATA_W-1:0]   o_dout_b
);

   state_t              r_state;
   logic [MAX_LOG2-1:0] r_idx;
   logic [LW-1:0]       r_log2n;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic                r_we;

   logic [MAX_LOG2-1:0] w_rev;
   logic [MAX_LOG2-1:0] w_last;
   logic                w_stop;
   logic                w_size_bad;

   bit_rev_idx #(
      .MAX_LOG2 (MAX_LOG2),
      .LW       (LW)
   ) u_rev (
      .i_idx   (r_idx),
      .i_log2n (r_log2n),
      .o_rev   (w_rev)
   );

   // Last index of the captured size: a mask of L ones.
   always_comb begin
      w_last = '0;
      for (int b = 0; b < MAX_LOG2; b++) begin
         if (b < int'(r_log2n)) begin
            w_last[b] = 1'b1;
         end
      end
   end

   assign w_stop     = (r_idx == w_last) || i_abort;
   assign w_size_bad = (int'(i_log2n_in) < MIN_LOG2) || (int'(i_log2n_in) > MAX_LOG2);

   // Controller FSM; busy and write enable are registered from the next state,
   // done is a one-cycle pulse registered off the DONE state.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_log2n <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               r_we <= 1'b0;
               if (i_start) begin
                  r_log2n <= i_log2n_in;
                  r_err   <= w_size_bad;
                  if (w_size_bad) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx   <= '0;
                     r_state <= S_SCAN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_SCAN: begin
               if (w_rev > r_idx) begin
                  // read issued this cycle, data lands for the SWAP writes
                  r_state <= S_SWAP;
                  r_we    <= 1'b1;
               end else if (w_stop) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_SWAP: begin
               r_we <= 1'b0;
               if (w_stop) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_we    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_err            = r_err;
   assign o_addr_a         = r_idx;
   assign o_addr_b         = w_rev;
   assign o_write_enable_a = r_we;
   assign o_write_enable_b = r_we;

   // Cross-connect read data to write data: A gets old mem[rev(i)], B old mem[i].
   assign o_dout_a = i_din_b;
   assign o_dout_b = i_din_a;

endmodule

// File: tb/tb_bit_rev_reorder_ctrl.sv
// Self-checking bench: dual-port RAM model plus an index-level reference
// model of the reorder (which pairs swap, how many cycles, where abort lands).
module tb_bit_rev_reorder_ctrl;

   localparam int DW   = 18;
   localparam int AW   = 10;
   localparam int LW   = 4;
   localparam int NMAX = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [LW-1:0] log2n;
   logic          busy, done, err;
   logic [AW-1:0] addr_a, addr_b;
   logic          we_a, we_b;
   logic [DW-1:0] din_a, din_b, dout_a, dout_b;

   logic [DW-1:0] mem       [NMAX];
   logic [DW-1:0] init_data [NMAX];
   logic [DW-1:0] exp_mem   [NMAX];
   logic          do_load;

   int n_checks = 0;
   int n_errors = 0;

   bit_rev_reorder_ctrl #(
      .DATA_W   (DW),
      .MAX_LOG2 (AW),
      .MIN_LOG2 (3),
      .LW       (LW)
   ) dut (
      .i_clk            (clk),
      .i_reset_n        (rst_n),
      .i_start          (start),
      .i_abort          (abort),
      .i_log2n_in       (log2n),
      .o_busy           (busy),
      .o_done           (done),
      .o_err            (err),
      .o_addr_a         (addr_a),
      .o_addr_b         (addr_b),
      .o_write_enable_a (we_a),
      .o_write_enable_b (we_b),
      .i_din_a          (din_a),
      .i_din_b          (din_b),
      .o_dout_a         (dout_a),
      .o_dout_b         (dout_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Dual-port RAM, 1-cycle registered read, read-before-write.
   always @(posedge clk) begin
      if (do_load) begin
         mem <= init_data;
      end else begin
         if (we_a) mem[addr_a] <= dout_a;
         if (we_b) mem[addr_b] <= dout_b;
      end
      din_a <= mem[addr_a];
      din_b <= mem[addr_b];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic int ref_rev(input int v, input int len);
      int r = 0;
      for (int b = 0; b < len; b++) r = (r << 1) | ((v >> b) & 1);
      return r;
   endfunction

   // Reference: walk indices, swap each pair once; SCAN costs one cycle,
   // a swapped pair costs two and only its SWAP cycle honours abort.
   task automatic model_run(input int len, input int abort_at, output int cycles, output int writes);
      int c = 0;
      logic [DW-1:0] t;
      writes = 0;
      for (int i = 0; i < (1 << len); i++) begin
         int r;
         r = ref_rev(i, len);
         if (r > i) begin
            t          = exp_mem[i];
            exp_mem[i] = exp_mem[r];
            exp_mem[r] = t;
            writes++;
            c += 2;
         end else begin
            c += 1;
         end
         if (abort_at >= 0 && abort_at <= c - 1) break;
      end
      cycles = c;
   endtask

   task automatic load_ram(input bit ident);
      for (int k = 0; k < NMAX; k++) begin
         init_data[k] = ident ? DW'(k) : DW'($urandom);
         exp_mem[k]   = init_data[k];
      end
      @(negedge clk) do_load = 1'b1;
      @(negedge clk) do_load = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      int bad = 0;
      for (int k = 0; k < NMAX; k++) if (mem[k] !== exp_mem[k]) bad++;
      check(tag, bad, 0);
   endtask

   // One run: start pulse, optional abort from cycle abort_at, full checks.
   task automatic run_once(input int len, input int abort_at);
      int exp_c, exp_w, exp_err;
      int wr = 0, order_bad = 0, pair_bad = 0, late = 0, done_at = -1;
      if (len < 3 || len > AW) begin
         exp_c = 0; exp_w = 0; exp_err = 1;
      end else begin
         model_run(len, abort_at, exp_c, exp_w);
         exp_err = 0;
      end
      @(negedge clk);
      log2n = LW'(len);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("err_at_start", err, exp_err);
      for (int n = 0; n < 4000; n++) begin
         if (n == abort_at) abort = 1'b1;
         if (we_a) wr++;
         if (we_a !== we_b) pair_bad++;
         if (we_a && (addr_a >= addr_b)) order_bad++;
         if (done) begin
            done_at = n;
            break;
         end
         @(posedge clk);
         #1;
      end
      abort = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         if (we_a || we_b || done || busy) late++;
      end
      $display("run L=%0d abort_at=%0d: done@%0d writes=%0d err=%0d", len, abort_at, done_at, wr, err);
      check("done_cycle", done_at, exp_c + 1);
      check("write_cycles", wr, exp_w);
      check("we_pair", pair_bad, 0);
      check("addr_order", order_bad, 0);
      check("err_final", err, exp_err);
      check("after_done", late, 0);
      check_mem("ram_contents");
   endtask

   initial begin
      int c1, w1, d1 = -1, d2 = -1, ndone = 0, busy23 = 1, busy24 = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      log2n   = '0;
      do_load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {busy, done, err, we_a, we_b}, 0);
      check("rst_addr", {addr_a, addr_b}, 0);
      @(negedge clk) rst_n = 1'b1;

      // L=3 identity, abort ignored in IDLE
      abort = 1'b1;
      load_ram(1'b1);
      abort = 1'b0;
      run_once(3, -1);

      // L=10 identity
      load_ram(1'b1);
      run_once(10, -1);

      // below range, then a valid start clears err
      load_ram(1'b0);
      run_once(2, -1);
      run_once(4, -1);

      // abort during SWAP of 1<->4 (cycle 2)
      load_ram(1'b1);
      run_once(3, 2);
      check("abort_mem3", mem[3], 3);
      check("abort_mem4", mem[4], 1);

      // asynchronous reset mid-scan at L=5
      load_ram(1'b0);
      @(negedge clk);
      log2n = 5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_ctrl", {busy, done, err, we_a, we_b}, 0);
      check("async_rst_addr", {addr_a, addr_b}, 0);
      @(negedge clk) rst_n = 1'b1;
      load_ram(1'b0);
      run_once(5, -1);

      // start held high at L=4: two back-to-back runs restore the RAM
      load_ram(1'b0);
      model_run(4, -1, c1, w1);
      model_run(4, -1, c1, w1);
      @(negedge clk);
      log2n = 4;
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 70; n++) begin
         if (n == 30) start = 1'b0;
         if (n == c1 + 1) busy23 = busy;
         if (n == c1 + 2) busy24 = busy;
         if (done) begin
            ndone++;
            if (d1 < 0) d1 = n;
            else d2 = n;
         end
         @(posedge clk);
         #1;
      end
      $display("held start L=4: done pulses=%0d at %0d,%0d", ndone, d1, d2);
      check("held_ndone", ndone, 2);
      check("held_done1", d1, c1 + 1);
      check("held_done2", d2, 2 * (c1 + 1) + 1);
      check("held_busy_at_done", busy23, 0);
      check("held_busy_next", busy24, 1);
      check_mem("held_identity");

      // randomized runs, some out of range, some aborted
      for (int t = 0; t < 8; t++) begin
         int len, ab;
         len = (t == 3) ? int'($urandom_range(11, 15)) : int'($urandom_range(3, 10));
         ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1 << len)) : -1;
         load_ram(1'b0);
         run_once(len, ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
